ld_st_unit: RTL and testbench

LD_ST_UNIT -- requirements
Module: ld_st_unit

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/ld_st_unit.sv | 138 +++++++++++++
 tb/tb_ld_st_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared state encoding and constants for the load/store unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam int c_DATA_W      = 8;
  localparam int c_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage : lsu_pkg

`default_nettype wire

// File: rtl/ld_st_unit.sv
// ============================================================================
// Module   : ld_st_unit
// Purpose  : Single-outstanding load/store sequencer between a register file
//            and a byte-wide memory port. Optional mem_ack timeout is enabled
//            with macro LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ld_st_unit
  import lsu_pkg::*;
#(
  parameter int addr_w  = 4,
  parameter int TIMEOUT = c_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                is_store_i,
  input  logic [addr_w-1:0]   rd_addr_i,
  input  logic [c_DATA_W-1:0] base_val_i,
  input  logic [c_DATA_W-1:0] st_val_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [c_DATA_W-1:0] mem_addr_o,
  output logic [c_DATA_W-1:0] mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [c_DATA_W-1:0] mem_rdata_i,
  output logic                rf_wen_o,
  output logic [addr_w-1:0]   rf_waddr_o,
  output logic [c_DATA_W-1:0] rf_wdata_o,
  output logic                err_o
);

  lsu_state_e          state_q;
  logic                is_store_q;
  logic [addr_w-1:0]   rd_addr_q;
  logic [c_DATA_W-1:0] addr_q;
  logic [c_DATA_W-1:0] st_val_q;
  logic [c_DATA_W-1:0] ld_data_q;
  logic                w_expired;

`ifdef LSU_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1; expiry is decided on the last REQ cycle.
  localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [c_CNT_W-1:0] cnt_q;
  logic               err_q;

  assign w_expired = (cnt_q == c_CNT_W'(TIMEOUT - 1));
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign w_unused_timeout = |32'(TIMEOUT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      rd_addr_q  <= '0;
      addr_q     <= '0;
      st_val_q   <= '0;
      ld_data_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_store_q <= is_store_i;
            rd_addr_q  <= rd_addr_i;
            addr_q     <= base_val_i;
            st_val_q   <= st_val_i;
            state_q    <= REQ;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        REQ: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (mem_ack_i) begin
            if (is_store_q) begin
              state_q <= DONE;
            end else begin
              ld_data_q <= mem_rdata_i;
              state_q   <= WB;
            end
          end else if (w_expired) begin
            state_q <= DONE;
`ifdef LSU_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end else begin
`ifdef LSU_TIMEOUT_EN
            cnt_q <= cnt_q + c_CNT_W'(1);
`endif
          end
        end
        WB: begin
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & is_store_q;
  assign mem_addr_o  = mem_req_o ? addr_q   : '0;
  assign mem_wdata_o = mem_req_o ? st_val_q : '0;
  assign rf_wen_o    = (state_q == WB);
  assign rf_waddr_o  = rf_wen_o ? rd_addr_q : '0;
  assign rf_wdata_o  = rf_wen_o ? ld_data_q : '0;

`ifdef LSU_TIMEOUT_EN
  assign err_o = done_o & err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule : ld_st_unit

`default_nettype wire

// File: tb/tb_ld_st_unit.sv
// ============================================================================
// Module   : tb_ld_st_unit
// Purpose  : Self-checking bench for ld_st_unit; timeline-level reference
//            model, timeout scenarios follow macro LSU_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ld_st_unit;

  localparam int c_AW = 4;
  localparam int c_TO = 15;
`ifdef LSU_TIMEOUT_EN
  localparam bit c_TO_EN = 1'b1;
`else
  localparam bit c_TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i, is_store_i;
  logic [c_AW-1:0] rd_addr_i;
  logic [7:0]      base_val_i, st_val_i;
  logic            busy_o, done_o, mem_req_o, mem_we_o;
  logic [7:0]      mem_addr_o, mem_wdata_o;
  logic            mem_ack_i;
  logic [7:0]      mem_rdata_i;
  logic            rf_wen_o;
  logic [c_AW-1:0] rf_waddr_o;
  logic [7:0]      rf_wdata_o;
  logic            err_o;

  int n_chk  = 0;
  int n_pass = 0;

  ld_st_unit #(.addr_w(c_AW), .TIMEOUT(c_TO)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .is_store_i (is_store_i),
    .rd_addr_i  (rd_addr_i),
    .base_val_i (base_val_i),
    .st_val_i   (st_val_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .rf_wen_o   (rf_wen_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy_o),      32'd0);
    chk({tag, "_done"},  32'(done_o),      32'd0);
    chk({tag, "_err"},   32'(err_o),       32'd0);
    chk({tag, "_req"},   32'(mem_req_o),   32'd0);
    chk({tag, "_we"},    32'(mem_we_o),    32'd0);
    chk({tag, "_addr"},  32'(mem_addr_o),  32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    chk({tag, "_wen"},   32'(rf_wen_o),    32'd0);
    chk({tag, "_waddr"}, 32'(rf_waddr_o),  32'd0);
    chk({tag, "_rfdat"}, 32'(rf_wdata_o),  32'd0);
  endtask

  // One operation: start in an IDLE cycle (cycle 0), ack after d waiting
  // REQ cycles (d >= TIMEOUT means it never arrives in time). Expected
  // cycle-by-cycle timeline is derived from the op description alone.
  task automatic run_op(input bit st, input logic [7:0] a, input logic [7:0] wd,
                        input logic [c_AW-1:0] rd, input int d,
                        input logic [7:0] rdv, input bit noise);
    bit to, wb;
    int req_len, last;
    to      = c_TO_EN && (d >= c_TO);
    req_len = to ? c_TO : d + 1;
    wb      = !st && !to;
    last    = req_len + (wb ? 1 : 0) + 1;

    @(posedge clk); #1;
    start_i = 1'b1; is_store_i = st; rd_addr_i = rd; base_val_i = a; st_val_i = wd;
    mem_ack_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_rdata_i = 8'($urandom);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_done", 32'(done_o), 32'd0);

    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        is_store_i = 1'($urandom); rd_addr_i = c_AW'($urandom);
        base_val_i = 8'($urandom); st_val_i = 8'($urandom);
      end
      mem_rdata_i = 8'($urandom);
      if (c <= req_len) mem_ack_i = (c == d + 1);
      else              mem_ack_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == d + 1 && c <= req_len) mem_rdata_i = rdv;
      @(negedge clk);
      chk("busy",    32'(busy_o),    32'd1);
      chk("done",    32'(done_o),    32'(c == last));
      chk("err",     32'(err_o),     32'(to && c == last));
      chk("mem_req", 32'(mem_req_o), 32'(c <= req_len));
      chk("mem_we",  32'(mem_we_o),  32'(st && c <= req_len));
      if (c <= req_len) begin
        chk("mem_addr",  32'(mem_addr_o),  32'(a));
        chk("mem_wdata", 32'(mem_wdata_o), 32'(wd));
      end
      chk("rf_wen", 32'(rf_wen_o), 32'(wb && c == req_len + 1));
      if (wb && c == req_len + 1) begin
        chk("rf_waddr", 32'(rf_waddr_o), 32'(rd));
        chk("rf_wdata", 32'(rf_wdata_o), 32'(rdv));
      end
    end
    start_i = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; is_store_i = 1'b0; rd_addr_i = '0;
    base_val_i = '0; st_val_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed load and delayed-ack store.
    run_op(1'b0, 8'h20, 8'h00, 4'd3, 0, 8'hA5, 1'b0);
    run_op(1'b1, 8'h10, 8'h5C, 4'd0, 4, 8'h00, 1'b0);
    // Load with start hammered every cycle and stray acks outside REQ.
    run_op(1'b0, 8'h33, 8'h99, 4'd9, 2, 8'h3C, 1'b1);

    // Asynchronous reset during REQ.
    @(posedge clk); #1;
    start_i = 1'b1; is_store_i = 1'b0; rd_addr_i = 4'd5; base_val_i = 8'h44; mem_ack_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("rst_pre_req", 32'(mem_req_o), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 8'h77;
    @(negedge clk);
    chk("rst_hold_wen",  32'(rf_wen_o), 32'd0);
    chk("rst_hold_busy", 32'(busy_o),   32'd0);
    start_i = 1'b1; is_store_i = 1'b1; base_val_i = 8'h6B; st_val_i = 8'h3E; mem_ack_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy_o),     32'd1);
    chk("post_rst_req",  32'(mem_req_o),  32'd1);
    chk("post_rst_we",   32'(mem_we_o),   32'd1);
    chk("post_rst_addr", 32'(mem_addr_o), 32'h6B);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done_o),   32'd1);
    chk("post_rst_wen",  32'(rf_wen_o), 32'd0);

    // Long waits around the timeout boundary (indefinite wait when disabled).
    run_op(1'b0, 8'hC1, 8'h12, 4'd7,  c_TO - 1, 8'h5A, 1'b0);
    run_op(1'b0, 8'hC2, 8'h34, 4'd8,  c_TO,     8'h6B, 1'b0);
    run_op(1'b1, 8'hC3, 8'h56, 4'd1,  c_TO + 4, 8'h00, 1'b1);
    run_op(1'b0, 8'hC4, 8'h78, 4'd15, c_TO + 4, 8'hE7, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), 8'($urandom), 8'($urandom), c_AW'($urandom),
             int'($urandom_range(0, 6)), 8'($urandom), 1'($urandom));

    @(posedge clk); #1;
    @(negedge clk);
    chk("final_busy", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ld_st_unit

`default_nettype wire
